// File: rtl/mod_148_dplca_txop_table_pkg.sv
// ---------------------------------------------------------------------------
// mod_148_dplca_pkg
// Shared definitions for the DPLCA transmit-opportunity table manager:
//   - claim_e : TXOP claim encodings as driven by the PLCA control FSM
//   - ON/OFF, TRUE/FALSE single-bit constants
//   - state_e : table-manager FSM state encodings
// ---------------------------------------------------------------------------
package mod_148_dplca_pkg;

    // Encodings are fixed by the control FSM; 2'b11 is undefined and decoded as NONE.
    typedef enum logic [1:0] {
        CLAIM_SOFT = 2'b00,
        CLAIM_HARD = 2'b01,
        CLAIM_NONE = 2'b10
    } claim_e;

    localparam logic ON    = 1'b1;
    localparam logic OFF   = 1'b0;
    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StUpdate = 2'd1,
        StAck    = 2'd2,
        StScan   = 2'd3
    } state_e;

endpackage

// File: rtl/mod_148_dplca_txop_table_if.sv
// ---------------------------------------------------------------------------
// mod_148_dplca_txop_table_if
// NEXT_TX_OPPORTUNITY handshake between the PLCA control FSM and the DPLCA
// TXOP table manager.
//   dplca_txop_end        control -> table  level, high in NEXT_TX_OPPORTUNITY
//   dplca_txop_id   [7:0] control -> table  ID of the closing TXOP
//   dplca_txop_claim[1:0] control -> table  claim seen in that TXOP
//   dplca_txop_table_upd  table -> control  table updated for this txop_end
// Modports: master = control FSM side, slave = table manager side.
// ---------------------------------------------------------------------------
interface mod_148_dplca_txop_table_if;
    logic       dplca_txop_end;
    logic [7:0] dplca_txop_id;
    logic [1:0] dplca_txop_claim;
    logic       dplca_txop_table_upd;

    modport master (
        output dplca_txop_end,
        output dplca_txop_id,
        output dplca_txop_claim,
        input  dplca_txop_table_upd
    );

    modport slave (
        input  dplca_txop_end,
        input  dplca_txop_id,
        input  dplca_txop_claim,
        output dplca_txop_table_upd
    );
endinterface

// File: rtl/mod_148_dplca_age_ram.sv
// ---------------------------------------------------------------------------
// mod_148_dplca_age_ram
// NUM_ENTRIES x AGE_W register file holding the per-ID claim age.
//   clk    in           clock
//   clr    in           synchronous clear of all entries (wins over write)
//   we     in           write enable
//   waddr  in  ADDR_W   write address
//   wdata  in  AGE_W    write data
//   raddr  in  ADDR_W   read address
//   rdata  out AGE_W    combinational read data
// ---------------------------------------------------------------------------
module mod_148_dplca_age_ram #(
    parameter int unsigned NUM_ENTRIES = 32,
    parameter int unsigned AGE_W       = 4,
    parameter int unsigned ADDR_W      = 5
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [AGE_W-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [AGE_W-1:0]  rdata
);
    logic [AGE_W-1:0] mem_q [NUM_ENTRIES];

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/mod_148_dplca_txop_table.sv
// ---------------------------------------------------------------------------
// mod_148_dplca_txop_table
// DPLCA transmit-opportunity table manager beside the PLCA control FSM.
// Keeps a per-ID claim age, acknowledges each NEXT_TX_OPPORTUNITY with
// dplca_txop_table_upd, and on every cycle_start scans the table to derive
// the effective plca_node_count.
// Ports:
//   clk                  in       clock
//   plca_reset           in       synchronous active-high reset
//   dplca_en             in       DPLCA enable (low behaves like reset)
//   dplca_aging          in       ON = NONE visits decrement the entry age
//   plca_node_count_cfg  in  [7:0] static node count used when disabled
//   cycle_start          in       pulse on control FSM entry to SYNCING
//   txop                 slave    TXOP handshake (see _if)
//   plca_node_count      out [7:0] effective node count
//   dplca_local_id       out [7:0] free local ID, 255 when none / not built
//   busy                 out      FSM not idle
// Build option: define DPLCA_AUTO_ID_EN to build free local-ID discovery;
// otherwise dplca_local_id is tied to 255.
// ---------------------------------------------------------------------------
module mod_148_dplca_txop_table
    import mod_148_dplca_pkg::*;
#(
    parameter int unsigned MAX_NODES      = 32,
    parameter int unsigned AGE_W          = 4,
    parameter int unsigned AGE_MAX        = 8,
    parameter int unsigned AGE_SOFT       = 2,
    parameter int unsigned MIN_NODE_COUNT = 8
) (
    input  logic                             clk,
    input  logic                             plca_reset,
    input  logic                             dplca_en,
    input  logic                             dplca_aging,
    input  logic [7:0]                       plca_node_count_cfg,
    input  logic                             cycle_start,
    mod_148_dplca_txop_table_if.slave        txop,
    output logic [7:0]                       plca_node_count,
    output logic [7:0]                       dplca_local_id,
    output logic                             busy
);
    localparam int unsigned       AW       = (MAX_NODES > 1) ? $clog2(MAX_NODES) : 1;
    localparam logic [AGE_W-1:0]  AgeMax   = AGE_W'(AGE_MAX);
    localparam logic [AGE_W-1:0]  AgeSoft  = AGE_W'(AGE_SOFT);
    localparam logic [8:0]        NodesMax = 9'(MAX_NODES);
    localparam logic [8:0]        NodesMin = 9'(MIN_NODE_COUNT);
    localparam logic [AW-1:0]     LastIdx  = AW'(MAX_NODES - 1);

    state_e           state_q, state_d;
    logic             clr;
    logic             txop_end_d;
    logic             txop_rise;
    logic             scan_last;
    logic             id_valid;
    logic [7:0]       id_q;
    logic [1:0]       claim_q;
    logic             pend_q;
    logic             scan_pend_q;
    logic [AW-1:0]    idx_q;
    logic [AW-1:0]    hi_q, hi_d;
    logic             hi_found_q, hi_found_d;
    logic             entry_active;
    logic [7:0]       node_count_q;
    logic [8:0]       count_raw;
    logic [7:0]       count_clamped;
    logic             table_upd_q;
    logic             ram_we;
    logic [AW-1:0]    ram_raddr;
    logic [AGE_W-1:0] ram_rdata, ram_wdata;

    // Disabling DPLCA is treated exactly like a reset.
    assign clr       = plca_reset | ~dplca_en;
    assign txop_rise = txop.dplca_txop_end & ~txop_end_d;
    assign scan_last = (idx_q == LastIdx);
    assign id_valid  = ({1'b0, id_q} < NodesMax);

    // Follows the input even in reset so a txop_end still high at reset
    // release is not mistaken for a new rising edge.
    always_ff @(posedge clk) begin
        txop_end_d <= txop.dplca_txop_end;
    end

    // ----------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                // A closing TXOP beats a scan request.
                if (txop_rise) begin
                    state_d = StUpdate;
                end else if (cycle_start || scan_pend_q) begin
                    state_d = StScan;
                end
            end
            StUpdate: state_d = StAck;
            StAck: begin
                if (!txop.dplca_txop_end) begin
                    state_d = StIdle;
                end
            end
            StScan: begin
                if (scan_last) begin
                    state_d = (pend_q || txop_rise) ? StUpdate : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy      = (state_q != StIdle);
        ram_we    = (state_q == StUpdate) && id_valid;
        ram_raddr = (state_q == StScan) ? idx_q : id_q[AW-1:0];
        ram_wdata = ram_rdata;
        if (claim_q == CLAIM_HARD) begin
            ram_wdata = AgeMax;
        end else if (claim_q == CLAIM_SOFT) begin
            if (ram_rdata < AgeSoft) begin
                ram_wdata = AgeSoft;
            end
        end else if (dplca_aging == ON && ram_rdata != '0) begin
            // NONE and undefined claims: one step of aging per visit.
            ram_wdata = ram_rdata - 1'b1;
        end
    end

    // ----------------------------------------------------------- age table
    mod_148_dplca_age_ram #(
        .NUM_ENTRIES (MAX_NODES),
        .AGE_W       (AGE_W),
        .ADDR_W      (AW)
    ) u_age_ram (
        .clk   (clk),
        .clr   (clr),
        .we    (ram_we),
        .waddr (id_q[AW-1:0]),
        .wdata (ram_wdata),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    // -------------------------------------------------------- scan datapath
    assign entry_active = (ram_rdata != '0);
    assign hi_d         = entry_active ? idx_q : hi_q;
    assign hi_found_d   = hi_found_q | entry_active;

    always_comb begin
        count_raw = hi_found_d ? (9'(hi_d) + 9'd2) : NodesMin;
        if (count_raw < NodesMin) begin
            count_clamped = NodesMin[7:0];
        end else if (count_raw > NodesMax) begin
            count_clamped = NodesMax[7:0];
        end else begin
            count_clamped = count_raw[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            id_q         <= 8'hFF;
            claim_q      <= CLAIM_NONE;
            pend_q       <= FALSE;
            scan_pend_q  <= FALSE;
            idx_q        <= '0;
            hi_q         <= '0;
            hi_found_q   <= FALSE;
            node_count_q <= plca_node_count_cfg;
            table_upd_q  <= FALSE;
        end else begin
            // Capture only where the edge is going to be serviced.
            if (txop_rise && (state_q == StIdle || state_q == StScan)) begin
                id_q    <= txop.dplca_txop_id;
                claim_q <= txop.dplca_txop_claim;
            end

            if (state_q == StScan) begin
                pend_q <= scan_last ? FALSE : (pend_q | txop_rise);
            end

            if (cycle_start && (state_q == StUpdate || state_q == StAck ||
                                (state_q == StIdle && txop_rise))) begin
                scan_pend_q <= TRUE;
            end else if (state_q == StIdle && state_d == StScan) begin
                scan_pend_q <= FALSE;
            end

            if (state_q == StScan) begin
                idx_q      <= scan_last ? '0 : idx_q + 1'b1;
                hi_q       <= scan_last ? '0 : hi_d;
                hi_found_q <= scan_last ? FALSE : hi_found_d;
                if (scan_last) begin
                    node_count_q <= count_clamped;
                end
            end

            if (state_q == StUpdate) begin
                table_upd_q <= TRUE;
            end else if (state_q == StAck && !txop.dplca_txop_end) begin
                table_upd_q <= FALSE;
            end
        end
    end

    assign txop.dplca_txop_table_upd = table_upd_q;
    assign plca_node_count           = dplca_en ? node_count_q : plca_node_count_cfg;

    // ------------------------------------------------------ free local ID
`ifdef DPLCA_AUTO_ID_EN
    logic [AW-1:0] free_q;
    logic          free_found_q;
    logic          free_hit;
    logic [7:0]    local_id_q;

    // ID 0 is the coordinator and never offered as a local ID.
    assign free_hit = (idx_q != '0) && !entry_active && !free_found_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            free_q       <= '0;
            free_found_q <= FALSE;
            local_id_q   <= 8'hFF;
        end else if (state_q == StScan) begin
            if (scan_last) begin
                free_q       <= '0;
                free_found_q <= FALSE;
                if (free_found_q) begin
                    local_id_q <= 8'(free_q);
                end else if (free_hit) begin
                    local_id_q <= 8'(idx_q);
                end else begin
                    local_id_q <= 8'hFF;
                end
            end else if (free_hit) begin
                free_q       <= idx_q;
                free_found_q <= TRUE;
            end
        end
    end

    assign dplca_local_id = local_id_q;
`else
    assign dplca_local_id = 8'hFF;
`endif

endmodule

// File: tb/tb_mod_148_dplca_txop_table.sv
module tb_mod_148_dplca_txop_table;
    import mod_148_dplca_pkg::*;

    logic       clk = 1'b0;
    logic       plca_reset;
    logic       dplca_en;
    logic       dplca_aging;
    logic [7:0] plca_node_count_cfg;
    logic       cycle_start;
    logic [7:0] plca_node_count;
    logic [7:0] dplca_local_id;
    logic       busy;

    mod_148_dplca_txop_table_if txop_if ();

    mod_148_dplca_txop_table dut (
        .clk                 (clk),
        .plca_reset          (plca_reset),
        .dplca_en            (dplca_en),
        .dplca_aging         (dplca_aging),
        .plca_node_count_cfg (plca_node_count_cfg),
        .cycle_start         (cycle_start),
        .txop                (txop_if),
        .plca_node_count     (plca_node_count),
        .dplca_local_id      (dplca_local_id),
        .busy                (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int exp_q[$];

    typedef struct {
        logic [7:0] id;
        logic [1:0] claim;
        logic       aging;
        logic       scan;
        int         exp_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic finish_scan(input string name);
        int n = 0;
        int exp;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        check({name, "_len"}, n, 32);
        exp = exp_q.pop_front();
        check({name, "_cnt"}, int'(plca_node_count), exp);
        check({name, "_upd"}, int'(txop_if.dplca_txop_table_upd), 0);
    endtask

    task automatic do_scan(input int exp, input string name);
        exp_q.push_back(exp);
        cycle_start = 1'b1;
        tick();
        cycle_start = 1'b0;
        finish_scan(name);
    endtask

    task automatic do_txop(input logic [7:0] id, input logic [1:0] claim, input logic aging,
                           input string name);
        int n = 0;
        dplca_aging                = aging;
        txop_if.dplca_txop_id      = id;
        txop_if.dplca_txop_claim   = claim;
        txop_if.dplca_txop_end     = 1'b1;
        do begin
            tick();
            n++;
        end while (!txop_if.dplca_txop_table_upd && n < 20);
        check({name, "_upd_latency"}, n, 2);
        repeat (2) tick();
        check({name, "_upd_hold"}, int'(txop_if.dplca_txop_table_upd), 1);
        txop_if.dplca_txop_end = 1'b0;
        tick();
        check({name, "_upd_drop"}, int'(txop_if.dplca_txop_table_upd), 0);
        check({name, "_idle"}, int'(busy), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;

        // id, claim, aging, scan-after, expected node count
        vecs.push_back('{8'd20,  CLAIM_HARD, ON,  1'b1, 22});
        vecs.push_back('{8'd31,  CLAIM_SOFT, ON,  1'b1, 32});
        vecs.push_back('{8'd31,  CLAIM_NONE, ON,  1'b1, 32});
        vecs.push_back('{8'd31,  CLAIM_NONE, ON,  1'b1, 22});
        vecs.push_back('{8'd31,  CLAIM_NONE, ON,  1'b1, 22});
        vecs.push_back('{8'd3,   CLAIM_SOFT, ON,  1'b1, 22});
        vecs.push_back('{8'd255, CLAIM_HARD, ON,  1'b1, 22});
        vecs.push_back('{8'd40,  CLAIM_HARD, ON,  1'b1, 22});
        vecs.push_back('{8'd20,  CLAIM_NONE, OFF, 1'b1, 22});
        vecs.push_back('{8'd20,  CLAIM_SOFT, ON,  1'b1, 22});
        vecs.push_back('{8'd20,  2'b11,      ON,  1'b1, 22});
        for (int k = 0; k < 6; k++) begin
            vecs.push_back('{8'd20, CLAIM_NONE, ON, 1'b0, 0});
        end
        vecs.push_back('{8'd20,  CLAIM_NONE, ON,  1'b1, 8});
        vecs.push_back('{8'd7,   CLAIM_HARD, ON,  1'b1, 9});
        vecs.push_back('{8'd7,   CLAIM_NONE, OFF, 1'b1, 9});

        plca_reset                   = 1'b1;
        dplca_en                     = 1'b1;
        dplca_aging                  = ON;
        plca_node_count_cfg          = 8'd5;
        cycle_start                  = 1'b0;
        txop_if.dplca_txop_end       = 1'b0;
        txop_if.dplca_txop_id        = 8'd0;
        txop_if.dplca_txop_claim     = CLAIM_NONE;
        repeat (3) tick();
        plca_reset = 1'b0;

        check("rst_cnt", int'(plca_node_count), 5);
        check("rst_upd", int'(txop_if.dplca_txop_table_upd), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_local_id", int'(dplca_local_id), 255);

        do_scan(8, "empty_scan");

        for (int i = 0; i < vecs.size(); i++) begin
            do_txop(vecs[i].id, vecs[i].claim, vecs[i].aging, $sformatf("vec%0d", i));
            if (vecs[i].scan) begin
                do_scan(vecs[i].exp_cnt, $sformatf("vec%0d_scan", i));
            end
        end

        // Local ID discovery after IDs 1..3 are claimed.
        do_txop(8'd1, CLAIM_HARD, ON, "id1");
        do_txop(8'd2, CLAIM_HARD, ON, "id2");
        do_txop(8'd3, CLAIM_HARD, ON, "id3");
        do_scan(9, "auto_id_scan");
`ifdef DPLCA_AUTO_ID_EN
        check("auto_local_id", int'(dplca_local_id), 4);
`else
        check("auto_local_id", int'(dplca_local_id), 255);
`endif

        // txop_end rises mid-scan: update deferred until the scan ends.
        exp_q.push_back(9);
        cycle_start = 1'b1;
        tick();
        cycle_start = 1'b0;
        repeat (10) tick();
        dplca_aging              = ON;
        txop_if.dplca_txop_id    = 8'd25;
        txop_if.dplca_txop_claim = CLAIM_HARD;
        txop_if.dplca_txop_end   = 1'b1;
        n = 0;
        while (!txop_if.dplca_txop_table_upd && n < 100) begin
            tick();
            n++;
        end
        check("pend_upd_latency", n, 23);
        check("pend_scan_cnt", int'(plca_node_count), exp_q.pop_front());

        // cycle_start during ACK: scan runs once the handshake closes.
        exp_q.push_back(27);
        cycle_start = 1'b1;
        tick();
        cycle_start = 1'b0;
        check("pend_upd_hold", int'(txop_if.dplca_txop_table_upd), 1);
        txop_if.dplca_txop_end = 1'b0;
        tick();
        check("pend_upd_drop", int'(txop_if.dplca_txop_table_upd), 0);
        check("scan_pend_gap", int'(busy), 0);
        tick();
        check("scan_pend_start", int'(busy), 1);
        finish_scan("scan_pend");

        // Reset in the middle of ACK.
        txop_if.dplca_txop_id    = 8'd1;
        txop_if.dplca_txop_claim = CLAIM_HARD;
        txop_if.dplca_txop_end   = 1'b1;
        n = 0;
        while (!txop_if.dplca_txop_table_upd && n < 20) begin
            tick();
            n++;
        end
        check("rst_ack_upd", int'(txop_if.dplca_txop_table_upd), 1);
        plca_reset = 1'b1;
        tick();
        check("rst_ack_upd_clr", int'(txop_if.dplca_txop_table_upd), 0);
        check("rst_ack_local_id", int'(dplca_local_id), 255);
        check("rst_ack_busy", int'(busy), 0);
        check("rst_ack_cnt", int'(plca_node_count), 5);
        plca_reset             = 1'b0;
        txop_if.dplca_txop_end = 1'b0;
        tick();
        do_scan(8, "post_rst_scan");
`ifdef DPLCA_AUTO_ID_EN
        check("post_rst_local_id", int'(dplca_local_id), 1);
`else
        check("post_rst_local_id", int'(dplca_local_id), 255);
`endif

        // Reset in the middle of SCAN.
        cycle_start = 1'b1;
        tick();
        cycle_start = 1'b0;
        repeat (5) tick();
        check("mid_scan_busy", int'(busy), 1);
        plca_reset = 1'b1;
        tick();
        check("rst_scan_busy", int'(busy), 0);
        check("rst_scan_cnt", int'(plca_node_count), 5);
        plca_reset = 1'b0;
        tick();

        // DPLCA disabled: static count, no handshake, table held clear.
        dplca_en            = 1'b0;
        plca_node_count_cfg = 8'd12;
        tick();
        check("dis_cnt", int'(plca_node_count), 12);
        txop_if.dplca_txop_id    = 8'd5;
        txop_if.dplca_txop_claim = CLAIM_HARD;
        txop_if.dplca_txop_end   = 1'b1;
        repeat (3) tick();
        check("dis_upd", int'(txop_if.dplca_txop_table_upd), 0);
        check("dis_busy", int'(busy), 0);
        txop_if.dplca_txop_end = 1'b0;
        tick();
        dplca_en = 1'b1;
        tick();
        check("en_cnt", int'(plca_node_count), 12);
        do_scan(8, "post_en_scan");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
